// File: rtl/mem_stream_fifo.sv
// mem_stream_fifo: synchronous FIFO buffering memory-fetched words ahead of the DSP datapath.
// Independent write/read handshakes, occupancy count, full/empty/almost flags and
// one-cycle overflow/underflow error pulses.
// Optional build macro: FWFT_EN (first-word fall-through read port). Without it,
// reads are registered with one cycle of latency from rd_en to rd_valid.
module mem_stream_fifo #(
   parameter int  DATA_WIDTH   = 8,
   parameter int  DEPTH        = 16,
   parameter int  AFULL_LEVEL  = 12,
   parameter int  AEMPTY_LEVEL = 4,
   localparam int ADDR_WIDTH   = $clog2(DEPTH)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  wr_en,
   input  logic [DATA_WIDTH-1:0] wr_data,
   input  logic                  rd_en,
   output logic [DATA_WIDTH-1:0] rd_data,
   output logic                  rd_valid,
   output logic                  full,
   output logic                  empty,
   output logic                  almost_full,
   output logic                  almost_empty,
   output logic [ADDR_WIDTH:0]   count,
   output logic                  overflow,
   output logic                  underflow
);

   // Thresholds resized to the count width so the flag compares are width-exact.
   localparam logic [ADDR_WIDTH:0] DEPTH_CNT  = (ADDR_WIDTH+1)'(DEPTH);
   localparam logic [ADDR_WIDTH:0] AFULL_CNT  = (ADDR_WIDTH+1)'(AFULL_LEVEL);
   localparam logic [ADDR_WIDTH:0] AEMPTY_CNT = (ADDR_WIDTH+1)'(AEMPTY_LEVEL);

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];

   logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
   logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
   logic [ADDR_WIDTH:0]   count_q, count_d;
   logic                  overflow_q, overflow_d;
   logic                  underflow_q, underflow_d;
   logic                  wr_acc, rd_acc;
   logic                  full_w, empty_w;

   // Status flags are pure decodes of the registered occupancy.
   always_comb begin
      full_w       = (count_q == DEPTH_CNT);
      empty_w      = (count_q == '0);
      full         = full_w;
      empty        = empty_w;
      almost_full  = (count_q >= AFULL_CNT);
      almost_empty = (count_q <= AEMPTY_CNT);
      count        = count_q;
      overflow     = overflow_q;
      underflow    = underflow_q;
   end

   // Accept decisions: a read at full frees the slot a simultaneous write needs.
   always_comb begin
      rd_acc      = rd_en & ~empty_w;
      wr_acc      = wr_en & (~full_w | rd_acc);
      wr_ptr_d    = wr_acc ? wr_ptr_q + ADDR_WIDTH'(1) : wr_ptr_q;
      rd_ptr_d    = rd_acc ? rd_ptr_q + ADDR_WIDTH'(1) : rd_ptr_q;
      count_d     = count_q;
      if (wr_acc && !rd_acc) begin
         count_d = count_q + (ADDR_WIDTH+1)'(1);
      end else if (rd_acc && !wr_acc) begin
         count_d = count_q - (ADDR_WIDTH+1)'(1);
      end
      overflow_d  = wr_en & full_w & ~rd_acc;
      underflow_d = rd_en & empty_w;
   end

   // Storage array is never reset; stale words are unreachable once pointers clear.
   always_ff @(posedge clk) begin
      if (wr_acc) begin
         mem_q[wr_ptr_q] <= wr_data;
      end
   end

   // Pointer, occupancy and error-pulse registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         overflow_q  <= overflow_d;
         underflow_q <= underflow_d;
      end
   end

`ifdef FWFT_EN
   // Head word is always visible; rd_en only acknowledges it.
   always_comb begin
      rd_data  = mem_q[rd_ptr_q];
      rd_valid = ~empty_w;
   end
`else
   logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
   logic                  rd_valid_q, rd_valid_d;

   // Registered read port: popped word lands one cycle after rd_en, else held.
   always_comb begin
      rd_data_d  = rd_acc ? mem_q[rd_ptr_q] : rd_data_q;
      rd_valid_d = rd_acc;
      rd_data    = rd_data_q;
      rd_valid   = rd_valid_q;
   end

   // Read-port output registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_data_q  <= '0;
         rd_valid_q <= 1'b0;
      end else begin
         rd_data_q  <= rd_data_d;
         rd_valid_q <= rd_valid_d;
      end
   end
`endif

endmodule

// File: tb/tb_mem_stream_fifo.sv
// Self-checking bench for mem_stream_fifo: directed scenarios plus a randomized run
// compared against a queue-based reference model. Honours FWFT_EN when defined.
module tb_mem_stream_fifo;

   localparam int DW    = 8;
   localparam int DEPTH = 16;
   localparam int AW    = 4;
   localparam int AFL   = 12;
   localparam int AEL   = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic          wr_en;
   logic [DW-1:0] wr_data;
   logic          rd_en;
   logic [DW-1:0] rd_data;
   logic          rd_valid;
   logic          full, empty, almost_full, almost_empty;
   logic [AW:0]   count;
   logic          overflow, underflow;

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model: the FIFO contents as a queue plus the expected registered outputs.
   logic [DW-1:0] q[$];
   logic [DW-1:0] m_rd_data = '0;
   logic          m_rd_valid = 1'b0;
   logic          m_ovf = 1'b0;
   logic          m_udf = 1'b0;

   mem_stream_fifo #(
      .DATA_WIDTH(DW), .DEPTH(DEPTH), .AFULL_LEVEL(AFL), .AEMPTY_LEVEL(AEL)
   ) dut (
      .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
      .rd_data(rd_data), .rd_valid(rd_valid), .full(full), .empty(empty),
      .almost_full(almost_full), .almost_empty(almost_empty), .count(count),
      .overflow(overflow), .underflow(underflow)
   );

   always #5 clk = ~clk;

   // One clock cycle of stimulus; the model is advanced from its pre-edge state.
   task automatic cyc(input logic w, input logic [DW-1:0] d, input logic r);
      bit was_empty, was_full, racc, wacc;
      logic [DW-1:0] popped;
      wr_en = w; wr_data = d; rd_en = r;
      @(posedge clk); #1;
      was_empty = (q.size() == 0);
      was_full  = (q.size() == DEPTH);
      racc   = r && !was_empty;
      wacc   = w && (!was_full || racc);
      m_ovf  = w && was_full && !racc;
      m_udf  = r && was_empty;
      popped = '0;
      if (racc) popped = q.pop_front();
      if (wacc) q.push_back(d);
`ifdef FWFT_EN
      m_rd_valid = (q.size() != 0);
      if (q.size() != 0) m_rd_data = q[0];
`else
      m_rd_valid = racc;
      if (racc) m_rd_data = popped;
`endif
      wr_en = 1'b0; rd_en = 1'b0;
   endtask

   task automatic model_reset();
      q.delete();
      m_rd_data = '0; m_rd_valid = 1'b0; m_ovf = 1'b0; m_udf = 1'b0;
   endtask

   task automatic test_reset();
      for (int i = 0; i < 5; i++) cyc(1'b1, DW'(8'h70 + i), 1'b0);
      n_tests++;
      if (count !== 5'd5) begin n_fail++; $display("FAIL reset_precount got=%0d exp=5", count); end
      #2 rst = 1'b1;
      #1;
      n_tests++;
      if (count !== 5'd0) begin n_fail++; $display("FAIL reset_count got=%0d exp=0", count); end
      n_tests++;
      if (empty !== 1'b1 || almost_empty !== 1'b1) begin
         n_fail++; $display("FAIL reset_empty got=%b/%b exp=1/1", empty, almost_empty);
      end
      n_tests++;
      if (full !== 1'b0 || almost_full !== 1'b0) begin
         n_fail++; $display("FAIL reset_full got=%b/%b exp=0/0", full, almost_full);
      end
      n_tests++;
      if (rd_valid !== 1'b0 || overflow !== 1'b0 || underflow !== 1'b0) begin
         n_fail++; $display("FAIL reset_pulses got=%b%b%b exp=000", rd_valid, overflow, underflow);
      end
`ifndef FWFT_EN
      n_tests++;
      if (rd_data !== 8'h00) begin n_fail++; $display("FAIL reset_rd_data got=%h exp=00", rd_data); end
`endif
      @(posedge clk); #1 rst = 1'b0;
      model_reset();
      cyc(1'b0, '0, 1'b1);
      n_tests++;
      if (underflow !== 1'b1) begin n_fail++; $display("FAIL reset_underflow got=%b exp=1", underflow); end
      n_tests++;
      if (rd_valid !== 1'b0 || count !== 5'd0) begin
         n_fail++; $display("FAIL reset_after_udf got valid=%b count=%0d exp 0/0", rd_valid, count);
      end
      cyc(1'b0, '0, 1'b0);
      n_tests++;
      if (underflow !== 1'b0) begin n_fail++; $display("FAIL udf_one_cycle got=%b exp=0", underflow); end
   endtask

   task automatic test_fill_drain();
      for (int i = 1; i <= 16; i++) cyc(1'b1, DW'(i), 1'b0);
      n_tests++;
      if (full !== 1'b1 || count !== 5'd16) begin
         n_fail++; $display("FAIL fill_full got full=%b count=%0d exp 1/16", full, count);
      end
      for (int i = 1; i <= 16; i++) begin
`ifdef FWFT_EN
         n_tests++;
         if (rd_valid !== 1'b1 || rd_data !== DW'(i)) begin
            n_fail++; $display("FAIL drain_word%0d got v=%b d=%h exp v=1 d=%h", i, rd_valid, rd_data, DW'(i));
         end
         cyc(1'b0, '0, 1'b1);
`else
         cyc(1'b0, '0, 1'b1);
         n_tests++;
         if (rd_valid !== 1'b1 || rd_data !== DW'(i)) begin
            n_fail++; $display("FAIL drain_word%0d got v=%b d=%h exp v=1 d=%h", i, rd_valid, rd_data, DW'(i));
         end
`endif
      end
      n_tests++;
      if (empty !== 1'b1 || count !== 5'd0) begin
         n_fail++; $display("FAIL drain_empty got empty=%b count=%0d exp 1/0", empty, count);
      end
   endtask

   task automatic test_overflow();
      for (int i = 0; i < 16; i++) cyc(1'b1, DW'(8'h20 + i), 1'b0);
      cyc(1'b1, 8'hAA, 1'b0);
      n_tests++;
      if (overflow !== 1'b1 || count !== 5'd16) begin
         n_fail++; $display("FAIL ovf_pulse got ovf=%b count=%0d exp 1/16", overflow, count);
      end
      cyc(1'b0, '0, 1'b0);
      n_tests++;
      if (overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_one_cycle got=%b exp=0", overflow); end
      for (int i = 0; i < 16; i++) begin
         cyc(1'b0, '0, 1'b1);
         n_tests++;
         if (rd_valid !== m_rd_valid || (m_rd_valid && (rd_data !== m_rd_data || rd_data === 8'hAA))) begin
            n_fail++; $display("FAIL ovf_drain%0d got v=%b d=%h exp v=%b d=%h", i, rd_valid, rd_data, m_rd_valid, m_rd_data);
         end
      end
      n_tests++;
      if (empty !== 1'b1) begin n_fail++; $display("FAIL ovf_empty got=%b exp=1", empty); end
   endtask

   task automatic test_simul_full();
      for (int i = 1; i <= 16; i++) cyc(1'b1, DW'(i), 1'b0);
      cyc(1'b1, 8'h55, 1'b1);
      n_tests++;
      if (count !== 5'd16 || full !== 1'b1 || overflow !== 1'b0) begin
         n_fail++; $display("FAIL simul_count got count=%0d full=%b ovf=%b exp 16/1/0", count, full, overflow);
      end
      n_tests++;
`ifdef FWFT_EN
      if (rd_data !== 8'h02) begin n_fail++; $display("FAIL simul_head got=%h exp=02", rd_data); end
`else
      if (rd_valid !== 1'b1 || rd_data !== 8'h01) begin
         n_fail++; $display("FAIL simul_oldest got v=%b d=%h exp v=1 d=01", rd_valid, rd_data);
      end
`endif
      for (int i = 0; i < 15; i++) cyc(1'b0, '0, 1'b1);
`ifdef FWFT_EN
      n_tests++;
      if (rd_valid !== 1'b1 || rd_data !== 8'h55) begin
         n_fail++; $display("FAIL simul_last got v=%b d=%h exp v=1 d=55", rd_valid, rd_data);
      end
      cyc(1'b0, '0, 1'b1);
`else
      cyc(1'b0, '0, 1'b1);
      n_tests++;
      if (rd_valid !== 1'b1 || rd_data !== 8'h55) begin
         n_fail++; $display("FAIL simul_last got v=%b d=%h exp v=1 d=55", rd_valid, rd_data);
      end
`endif
      n_tests++;
      if (empty !== 1'b1) begin n_fail++; $display("FAIL simul_empty got=%b exp=1", empty); end
   endtask

   task automatic test_wrap();
      for (int i = 0; i < 10; i++) cyc(1'b1, DW'(8'h80 + i), 1'b0);
      for (int i = 0; i < 8; i++)  cyc(1'b0, '0, 1'b1);
      for (int i = 0; i < 10; i++) cyc(1'b1, DW'(8'hC0 + i), 1'b0);
      n_tests++;
      if (count !== 5'd12 || almost_full !== 1'b1 || almost_empty !== 1'b0) begin
         n_fail++; $display("FAIL wrap_flags got count=%0d af=%b ae=%b exp 12/1/0", count, almost_full, almost_empty);
      end
      for (int i = 0; i < 12; i++) begin
         cyc(1'b0, '0, 1'b1);
         n_tests++;
         if (rd_valid !== m_rd_valid || (m_rd_valid && rd_data !== m_rd_data)) begin
            n_fail++; $display("FAIL wrap_order%0d got v=%b d=%h exp v=%b d=%h", i, rd_valid, rd_data, m_rd_valid, m_rd_data);
         end
      end
      n_tests++;
      if (empty !== 1'b1) begin n_fail++; $display("FAIL wrap_empty got=%b exp=1", empty); end
   endtask

`ifdef FWFT_EN
   task automatic test_fwft();
      cyc(1'b1, 8'h3C, 1'b0);
      n_tests++;
      if (rd_valid !== 1'b1 || rd_data !== 8'h3C) begin
         n_fail++; $display("FAIL fwft_present got v=%b d=%h exp v=1 d=3c", rd_valid, rd_data);
      end
      cyc(1'b0, '0, 1'b1);
      n_tests++;
      if (empty !== 1'b1 || rd_valid !== 1'b0) begin
         n_fail++; $display("FAIL fwft_pop got empty=%b v=%b exp 1/0", empty, rd_valid);
      end
   endtask
`endif

   task automatic test_random();
      int wp, rp, sz;
      for (int c = 0; c < 600; c++) begin
         wp = (c < 200) ? 70 : (c < 400) ? 30 : 50;
         rp = 100 - wp;
         cyc(($urandom_range(0, 99) < wp), DW'($urandom), ($urandom_range(0, 99) < rp));
         sz = q.size();
         n_tests++;
         if (count !== (AW+1)'(sz)) begin n_fail++; $display("FAIL rnd_count c=%0d got=%0d exp=%0d", c, count, sz); end
         n_tests++;
         if (full !== (sz == DEPTH) || empty !== (sz == 0) || almost_full !== (sz >= AFL) || almost_empty !== (sz <= AEL)) begin
            n_fail++; $display("FAIL rnd_flags c=%0d got f/e/af/ae=%b%b%b%b size=%0d", c, full, empty, almost_full, almost_empty, sz);
         end
         n_tests++;
         if (overflow !== m_ovf || underflow !== m_udf) begin
            n_fail++; $display("FAIL rnd_err c=%0d got o/u=%b%b exp=%b%b", c, overflow, underflow, m_ovf, m_udf);
         end
         n_tests++;
         if (rd_valid !== m_rd_valid || (m_rd_valid && rd_data !== m_rd_data)) begin
            n_fail++; $display("FAIL rnd_read c=%0d got v=%b d=%h exp v=%b d=%h", c, rd_valid, rd_data, m_rd_valid, m_rd_data);
         end
      end
   endtask

   initial begin
      rst = 1'b1; wr_en = 1'b0; wr_data = '0; rd_en = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      model_reset();
      test_reset();
      test_fill_drain();
      test_overflow();
      test_simul_full();
      test_wrap();
`ifdef FWFT_EN
      test_fwft();
`endif
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/mem_stream_fifo.md
Name: mem_stream_fifo

Overview:
- Parametrised synchronous FIFO that buffers a word stream fetched from on-chip memory before it reaches the DSP datapath.
- Successor to the single-enable memory-to-FIFO buffer. Adds:
  - independent write and read handshakes
  - full, empty and almost-full/almost-empty flags
  - an occupancy count
  - overflow and underflow error pulses
- Sits between the memory read port (producer) and the filter/MAC pipeline (consumer).

Parameters:
- DATA_WIDTH, 8, width of each stored word in bits.
- DEPTH, 16, number of entries. Must be a power of two and at least 2.
- AFULL_LEVEL, 12, almost_full asserts when count >= AFULL_LEVEL.
- AEMPTY_LEVEL, 4, almost_empty asserts when count <= AEMPTY_LEVEL.
- ADDR_WIDTH, $clog2(DEPTH), derived pointer width. Not to be overridden.

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- wr_en  in  1  producer write request.
- wr_data  in  DATA_WIDTH  word to store.
- rd_en  in  1  consumer read request.
- rd_data  out  DATA_WIDTH  read word.
- rd_valid  out  1  rd_data holds a newly popped word.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- almost_full  out  1  count >= AFULL_LEVEL.
- almost_empty  out  1  count <= AEMPTY_LEVEL.
- count  out  ADDR_WIDTH+1  current occupancy, 0..DEPTH.
- overflow  out  1  one-cycle pulse: a write was dropped.
- underflow  out  1  one-cycle pulse: a read was refused.

Behaviour:
- Reset (asynchronous assert, released synchronously to clk by the system):
  - write and read pointers = 0, count = 0.
  - rd_data = 0, rd_valid = 0, overflow = 0, underflow = 0.
  - empty = 1, almost_empty = 1, full = 0, almost_full = 0 (for AFULL_LEVEL > 0).
  - Memory contents are not cleared.
  - Reset mid-stream discards all buffered words.
- Accept rules:
  - rd_acc = rd_en & !empty.
  - wr_acc = wr_en & (!full | rd_acc). When full, a simultaneous read frees the slot, so both are accepted.
  - When empty with both asserted: only the write is accepted, and underflow pulses.
- Write: on wr_acc, mem[wr_ptr] <= wr_data and wr_ptr increments, wrapping modulo DEPTH (natural ADDR_WIDTH roll-over).
- Read (default mode):
  - On rd_acc, rd_data <= mem[rd_ptr], rd_valid <= 1 and rd_ptr increments with wrap. Latency is one cycle from rd_en to rd_valid.
  - When rd_acc is 0, rd_valid <= 0 and rd_data holds its last value.
- Count update per cycle:
  - wr_acc only: +1.
  - rd_acc only: -1.
  - both or neither: unchanged.
- Flags:
  - full, empty, almost_full and almost_empty are combinational decodes of the registered count.
  - They change in the cycle after the access that moves count.
- Errors:
  - overflow <= wr_en & full & !rd_acc.
  - underflow <= rd_en & empty.
  - Both are registered and high for exactly one cycle per offending request. Pointers and count are not affected.
- Capacity: exactly DEPTH words. No slot is sacrificed; the extra count bit distinguishes full from empty.

Optional Feature:
- FWFT_EN (first-word fall-through).
- Defined:
  - rd_data continuously presents mem[rd_ptr].
  - rd_valid = !empty, combinational from count.
  - rd_en acts as a pop/acknowledge. A word written into an empty FIFO appears on rd_data with rd_valid = 1 one cycle after its write edge.
  - Accept rules, count, flags and errors are unchanged.
- Undefined: registered one-cycle-latency read as described in Behaviour.

Test Plan:
- Reset check: assert rst asynchronously mid-cycle after 5 writes -> immediately count = 0, empty = 1, rd_valid = 0. The next read attempt pulses underflow.
- Fill/drain order: write 0x01..0x10 (16 words) -> full = 1, count = 16. Then read 16 -> rd_data 0x01..0x10 in order, each one cycle after rd_en; empty = 1 at the end.
- Overflow: when full, write 0xAA with rd_en = 0 -> overflow pulses 1 cycle, count stays 16, and 0xAA is never read out.
- Simultaneous at full: full FIFO, wr_en = rd_en = 1 with 0x55 -> count stays 16, the oldest word is output, and 0x55 is read last after 15 more reads.
- Wrap and thresholds: write 10, read 8, write 10 (pointers wrap) -> count = 12, almost_full = 1, almost_empty = 0. Data comes out in write order across the wrap.
- FWFT_EN build: write 0x3C into an empty FIFO -> next cycle rd_valid = 1, rd_data = 0x3C without rd_en. Pulse rd_en -> empty = 1 the following cycle.
